inha_led_game: RTL
==================

Name: inha_led_game

Overview:
- Parametrised successor of the `inha` LED/button game core.
- A single lit target rotates across an LED bar of configurable width.
- The player presses U when the target sits on the hit position.
  - L/R set the rotation direction; D toggles slow speed.
  - SW0 starts, SW1 pauses, SW2 reserved, SW3 aborts.
- Hit/miss counting drives the win/lose states shown on the RD/GN/YL lamps. The block sits directly behind board pins and drives the LED bar and lamps.

Parameters:
- LED_W, 8: LED bar width; target index range 0..LED_W-1.
- TICK_DIV, 4: clk cycles per target step in normal speed (>=2).
- ROUNDS, 8: hits required to win (>=1).
- MAX_MISS, 3: misses that cause a loss (>=1).
- HIT_POS, 0: target index counted as a hit (< LED_W).

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  synchronous active-low reset
- L, R, U, D  in  1 each  direction buttons, active-low (idle 1)
- SW0, SW1, SW2, SW3  in  1 each  function switches, active-low push (idle 1)
- LED  out  LED_W  LED bar, 1 = lit
- RD, GN, YL  out  1 each  status lamps, 1 = lit
- score  out  clog2(ROUNDS+1)  current hit count

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE; LED=0; RD=0; GN=0; YL=1; score=0; misses=0.
  - target=LED_W-1; dir=right; slow=0; tick counter=0.
  - All synchroniser flops = 1, so no press is pending.
- Reset asserted mid-game discards all progress.
- Inputs: each of the 8 pins passes a 2-flop synchroniser plus a previous-value flop. A press is a one-cycle pulse on the 1->0 transition of the synchronised value.
  - If a pin is first sampled low at edge E0, its effect is registered at E2.
  - Holding a pin low yields exactly one press.
- States:
  - IDLE: LED=0, YL=1.
    - SW0 press -> PLAY with score=0, misses=0, target=LED_W-1, dir=right, slow=0, tick=0.
  - PLAY: LED=one-hot(target), GN=1.
    - tick counts 0..P-1, with P=TICK_DIV (slow=0) or 2*TICK_DIV (slow=1). At tick==P-1, tick->0 and target steps.
    - Step direction: right = index-1, left = index+1, with wrap-around LED_W-1<->0.
    - L press: dir=left. R press: dir=right. L and R in the same cycle: dir unchanged.
    - D press: slow toggles; tick resets to 0.
    - U press: compares the pre-step target with HIT_POS in the same cycle as a step.
      - Equal: score+1.
      - Otherwise: misses+1.
    - Next cycle after score==ROUNDS: WIN. Next cycle after misses==MAX_MISS: LOSE.
    - SW1 press -> PAUSE.
  - PAUSE: LED frozen at one-hot(target), YL=1, GN=0; tick held; all U/L/R/D presses ignored.
    - SW1 press -> PLAY, resuming with the same tick value.
  - WIN: LED all ones, GN=1.
  - LOSE: LED=0, RD=1.
  - From WIN or LOSE: SW0 press -> PLAY, initialised as from IDLE.
- SW3 press in any state -> IDLE with reset values except synchronisers.
  - SW3 has priority over every other press in the same cycle.
- SW0 in PLAY/PAUSE and SW2 in any state: no effect.
- Lamps are mutually exclusive: exactly one of RD/GN/YL is 1 in every state.
- score saturates at ROUNDS; misses saturates at MAX_MISS.

Optional Feature:
- INHA_SCORE_DISPLAY_EN defined:
  - WIN: LED shows the score in binary, zero-extended/truncated to LED_W.
  - LOSE: LED shows the miss count in binary, with RD still 1.
- Not defined: WIN shows all ones, LOSE shows LED=0. No other behaviour differs.

Test Plan (LED_W=8, TICK_DIV=4, ROUNDS=3, MAX_MISS=2, HIT_POS=0):
- Reset, then SW0 low 1 cycle -> PLAY 2 edges later, LED=8'b1000_0000, GN=1. After 28 cycles LED=8'b0000_0001; 4 cycles later LED=8'b1000_0000 (wrap).
- Win path: three U presses, each landing while LED=8'b0000_0001 -> score 1,2,3, then WIN with LED=8'hFF, GN=1. With INHA_SCORE_DISPLAY_EN defined, LED=8'h03 instead.
- Lose path: two U presses while LED=8'b0001_0000 -> misses=2, LOSE, LED=0, RD=1, score=0. SW0 press then returns to PLAY with LED=8'h80.
- L press in PLAY -> target index increments, with wrap 7->0. D press -> step period 8 cycles. L and R held low together -> direction unchanged.
- SW1 press -> PAUSE: YL=1, LED frozen, U press ignored (score unchanged). Second SW1 press -> PLAY resumes with the same tick phase.
- SW3 pressed in the same cycle as SW0 and U during PLAY -> IDLE, LED=0, YL=1, score=0. rst_n low for 1 edge mid-PLAY -> reset values.

Source files
------------

// File: rtl/inha_led_game.sv
// inha_led_game: a lit target rotates across the LED bar; pressing U on HIT_POS scores, otherwise it counts a miss.
// A press takes effect 2 edges after the pin is first sampled low. Define INHA_SCORE_DISPLAY_EN to show score/misses on the bar in WIN/LOSE.
module inha_led_game #(
  parameter int LED_W    = 8,
  parameter int TICK_DIV = 4,
  parameter int ROUNDS   = 8,
  parameter int MAX_MISS = 3,
  parameter int HIT_POS  = 0,
  localparam int SC_W    = $clog2(ROUNDS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             L,
  input  logic             R,
  input  logic             U,
  input  logic             D,
  input  logic             SW0,
  input  logic             SW1,
  input  logic             SW2,
  input  logic             SW3,
  output logic [LED_W-1:0] LED,
  output logic             RD,
  output logic             GN,
  output logic             YL,
  output logic [SC_W-1:0]  score
);

  localparam int TG_W = (LED_W > 1) ? $clog2(LED_W) : 1;
  localparam int MS_W = $clog2(MAX_MISS + 1);
  localparam int CT_W = $clog2(2 * TICK_DIV);

  localparam logic [TG_W-1:0] TG_TOP = TG_W'(LED_W - 1);
  localparam logic [TG_W-1:0] TG_HIT = TG_W'(HIT_POS);
  localparam logic [SC_W-1:0] SC_MAX = SC_W'(ROUNDS);
  localparam logic [MS_W-1:0] MS_MAX = MS_W'(MAX_MISS);
  localparam logic [CT_W-1:0] P_FAST = CT_W'(TICK_DIV - 1);
  localparam logic [CT_W-1:0] P_SLOW = CT_W'(2 * TICK_DIV - 1);

  typedef enum logic [2:0] {IDLE, PLAY, PAUSE, WIN, LOSE} state_t;

  state_t          state, state_nx;
  logic [TG_W-1:0] target, target_step;
  logic [MS_W-1:0] misses;
  logic [CT_W-1:0] tick, period;
  logic            left, slow, clear;

  // Pins idle high; a press is the 1->0 edge of the synchronised level.
  logic [7:0] pins, sync1, sync2, prev, press;
  logic       p_l, p_r, p_u, p_d, p_sw0, p_sw1, p_sw3;
  logic       unused_sw2;

  assign pins = {SW3, SW2, SW1, SW0, D, U, R, L};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= '1;
      sync2 <= '1;
      prev  <= '1;
    end else begin
      sync1 <= pins;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign press      = prev & ~sync2;
  assign p_l        = press[0];
  assign p_r        = press[1];
  assign p_u        = press[2];
  assign p_d        = press[3];
  assign p_sw0      = press[4];
  assign p_sw1      = press[5];
  assign unused_sw2 = press[6];
  assign p_sw3      = press[7];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (p_sw3) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE, WIN, LOSE: if (p_sw0) state_nx = PLAY;
        PLAY: begin
          if (score == SC_MAX)       state_nx = WIN;
          else if (misses == MS_MAX) state_nx = LOSE;
          else if (p_sw1)            state_nx = PAUSE;
        end
        PAUSE:   if (p_sw1) state_nx = PLAY;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Abort and (re)start both load the power-on game values.
  assign clear  = p_sw3 || (p_sw0 && (state inside {IDLE, WIN, LOSE}));
  assign period = slow ? P_SLOW : P_FAST;

  always_comb begin
    if (left) target_step = (target == TG_TOP) ? '0 : target + TG_W'(1);
    else      target_step = (target == '0) ? TG_TOP : target - TG_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      target <= TG_TOP;
      left   <= 1'b0;
      slow   <= 1'b0;
      tick   <= '0;
      score  <= '0;
      misses <= '0;
    end else if (state == PLAY) begin
      if (p_l && !p_r)      left <= 1'b1;
      else if (p_r && !p_l) left <= 1'b0;

      if (p_d) begin
        slow <= ~slow;
        tick <= '0;
      end else if (tick == period) begin
        tick   <= '0;
        target <= target_step;
      end else begin
        tick <= tick + CT_W'(1);
      end

      // The hit test sees the target as it was before any step on this edge.
      if (p_u) begin
        if (target == TG_HIT) begin
          if (score != SC_MAX) score <= score + SC_W'(1);
        end else if (misses != MS_MAX) begin
          misses <= misses + MS_W'(1);
        end
      end
    end
  end

  always_comb begin
    LED = '0;
    RD  = 1'b0;
    GN  = 1'b0;
    YL  = 1'b0;
    case (state)
      IDLE: YL = 1'b1;
      PLAY: begin
        LED = LED_W'(1) << target;
        GN  = 1'b1;
      end
      PAUSE: begin
        LED = LED_W'(1) << target;
        YL  = 1'b1;
      end
      WIN: begin
        GN = 1'b1;
`ifdef INHA_SCORE_DISPLAY_EN
        LED = LED_W'(score);
`else
        LED = '1;
`endif
      end
      LOSE: begin
        RD = 1'b1;
`ifdef INHA_SCORE_DISPLAY_EN
        LED = LED_W'(misses);
`else
        LED = '0;
`endif
      end
      default: YL = 1'b1;
    endcase
  end

endmodule
